// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    // Line-fill controller states.
    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

    // Width of the word-offset field within a line.
    function automatic int unsigned off_width(input int unsigned words);
        return $clog2(words);
    endfunction

    // Width of the line-index field.
    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Width of the tag: whatever address bits remain above index and offset.
    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines,
                                              input int unsigned words);
        return addr_w - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Tag/data storage for the direct-mapped cache: async read, sync writes,
// per-line valid bits with a clear-all.
module icache_dm_array
    import icache_pkg::*;
#(
    parameter int unsigned LINES  = 16,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 2,
    localparam int unsigned IDX_W = idx_width(LINES),
    localparam int unsigned OFF_W = off_width(WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Read port
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              rd_valid_o,
    // Write port (data beat and line completion share the index)
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tag_wr_i,
    input  logic [TAG_W-1:0]  tag_wr_data_i,
    // Valid control
    input  logic              inv_i,
    input  logic [IDX_W-1:0]  inv_idx_i,
    input  logic              clr_all_i
);

    logic [DATA_W-1:0] r_data  [LINES][WORDS];
    logic [TAG_W-1:0]  r_tag   [LINES];
    logic [LINES-1:0]  r_valid;

    // Data words are written one beat at a time; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_data[wr_idx_i][wr_off_i] <= wr_data_i;
        end
    end

    // Tag is written once, on the final beat of a fill.
    always_ff @(posedge clk_i) begin
        if (tag_wr_i) begin
            r_tag[wr_idx_i] <= tag_wr_data_i;
        end
    end

    // Valid bits: clear-all wins over per-line invalidate and set.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_all_i) begin
            r_valid <= '0;
        end else begin
            if (inv_i) begin
                r_valid[inv_idx_i] <= 1'b0;
            end
            if (tag_wr_i) begin
                r_valid[wr_idx_i] <= 1'b1;
            end
        end
    end

    assign rd_data_o  = r_data[rd_idx_i][rd_off_i];
    assign rd_tag_o   = r_tag[rd_idx_i];
    assign rd_valid_o = r_valid[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hit path, line-fill FSM,
// flush, and saturating hit/miss counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINES  = 16,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              valid_o,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int unsigned OFF_W = off_width(WORDS);
    localparam int unsigned IDX_W = idx_width(LINES);
    localparam int unsigned TAG_W = tag_width(ADDR_W, LINES, WORDS);

    state_e             r_state;
    state_e             w_state_d;
    logic [OFF_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_fill_idx;
    logic [TAG_W-1:0]   r_fill_tag;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [DATA_W-1:0]  w_rd_data;
    logic [TAG_W-1:0]   w_rd_tag;
    logic               w_rd_valid;
    logic               w_hit;
    logic               w_start;
    logic               w_beat;
    logic               w_last;

    assign w_off = addr_i[OFF_W-1:0];
    assign w_idx = addr_i[OFF_W +: IDX_W];
    assign w_tag = addr_i[ADDR_W-1 -: TAG_W];

    // Hit uses the pre-flush valid bits, so a flush cycle can still hit.
    assign w_hit   = (r_state == StIdle) & req_i & w_rd_valid & (w_rd_tag == w_tag);
    assign w_start = (r_state == StIdle) & req_i & ~w_hit & ~flush_i;
    // A beat landing with a flush is dropped.
    assign w_beat  = (r_state == StFill) & mem_ack_i & ~flush_i;
    assign w_last  = w_beat & (r_cnt == OFF_W'(WORDS - 1));

    icache_dm_array #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_array (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rd_idx_i      (w_idx),
        .rd_off_i      (w_off),
        .rd_data_o     (w_rd_data),
        .rd_tag_o      (w_rd_tag),
        .rd_valid_o    (w_rd_valid),
        .wr_en_i       (w_beat),
        .wr_idx_i      (r_fill_idx),
        .wr_off_i      (r_cnt),
        .wr_data_i     (mem_rdata_i),
        .tag_wr_i      (w_last),
        .tag_wr_data_i (r_fill_tag),
        .inv_i         (w_start),
        .inv_idx_i     (w_idx),
        .clr_all_i     (flush_i)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic: flush aborts a fill, last acked beat completes it.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_start) w_state_d = StFill;
            StFill: if (flush_i || w_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Output logic: memory side is driven purely from registered state.
    always_comb begin
        valid_o    = w_hit;
        inst_o     = w_hit ? w_rd_data : '0;
        stall_o    = (req_i & ~w_hit) | (r_state == StFill);
        mem_req_o  = (r_state == StFill);
        mem_addr_o = (r_state == StFill) ? {r_fill_tag, r_fill_idx, r_cnt} : '0;
    end

    // Fill bookkeeping: capture the missing line and step the beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
        end else if (w_start) begin
            r_cnt      <= '0;
            r_fill_idx <= w_idx;
            r_fill_tag <= w_tag;
        end else if (w_beat) begin
            r_cnt      <= r_cnt + OFF_W'(1);
        end
    end

    // Saturating performance counters; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (w_start && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: main instance plus a 4-bit-counter instance
// for saturation.
module tb_icache_dm;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, flush, mem_ack;
    logic [7:0]  addr, mem_addr;
    logic [31:0] inst, mem_rdata;
    logic        valid, stall, mem_req;
    logic [15:0] hit_cnt, miss_cnt;

    logic        s_req;
    logic [7:0]  s_addr, s_mem_addr;
    logic [31:0] s_inst, s_mem_rdata;
    logic        s_valid, s_stall, s_mem_req;
    logic [3:0]  s_hit_cnt, s_miss_cnt;

    int checks = 0;
    int errors = 0;

    // Backing memory: word a holds 0xA000_0000 + a.
    assign mem_rdata   = 32'hA000_0000 + {24'd0, mem_addr};
    assign s_mem_rdata = 32'hA000_0000 + {24'd0, s_mem_addr};

    icache_dm #(.ADDR_W(8), .DATA_W(32), .LINES(16), .WORDS(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .inst_o(inst),
        .valid_o(valid), .stall_o(stall), .flush_i(flush), .mem_req_o(mem_req),
        .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    icache_dm #(.ADDR_W(8), .DATA_W(32), .LINES(16), .WORDS(4), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .req_i(s_req), .addr_i(s_addr), .inst_o(s_inst),
        .valid_o(s_valid), .stall_o(s_stall), .flush_i(1'b0), .mem_req_o(s_mem_req),
        .mem_addr_o(s_mem_addr), .mem_rdata_i(s_mem_rdata), .mem_ack_i(1'b1),
        .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; flush = 1'b0; mem_ack = 1'b0; addr = '0;
        s_req = 1'b0; s_addr = '0;
        tick; tick;
        rst = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", stall); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters: got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
        end
    endtask

    // Miss at cycle 0, four beats, then the held request hits.
    task automatic test_cold_miss;
        logic [7:0] e;
        req = 1'b1; addr = 8'h14; mem_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL cold_detect: got stall=%0h valid=%0h mem_req=%0h want 1/0/0", stall, valid, mem_req);
        end
        tick;
        for (int i = 0; i < 4; i++) begin
            e = 8'h14 + 8'(i);
            checks++; if (mem_req !== 1'b1 || mem_addr !== e || stall !== 1'b1) begin
                errors++; $display("FAIL cold_beat%0d: got req=%0h addr=%h stall=%0h want 1/%h/1", i, mem_req, mem_addr, stall, e);
            end
            tick;
        end
        checks++; if (valid !== 1'b1 || inst !== 32'hA000_0014 || stall !== 1'b0) begin
            errors++; $display("FAIL cold_hit: got valid=%0h inst=%h stall=%0h want 1/a0000014/0", valid, inst, stall);
        end
        tick;
        checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            errors++; $display("FAIL cold_counters: got hit=%0d miss=%0d want 1/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_line_reuse;
        logic [7:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 8'h14 + 8'(i);
            addr = a;
            #1;
            checks++; if (valid !== 1'b1 || inst !== (32'hA000_0000 + {24'd0, a}) || mem_req !== 1'b0) begin
                errors++; $display("FAIL reuse_%h: got valid=%0h inst=%h mem_req=%0h", a, valid, inst, mem_req);
            end
            tick;
        end
        checks++; if (hit_cnt !== 16'd5) begin errors++; $display("FAIL reuse_hit_cnt: got %0d want 5", hit_cnt); end
    endtask

    task automatic test_conflict;
        logic [7:0] e;
        addr = 8'h54; mem_ack = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL conflict_miss54: got valid=%0h stall=%0h want 0/1", valid, stall);
        end
        tick;
        for (int i = 0; i < 4; i++) begin
            e = 8'h54 + 8'(i);
            checks++; if (mem_addr !== e) begin errors++; $display("FAIL conflict_beat%0d: got %h want %h", i, mem_addr, e); end
            tick;
        end
        checks++; if (valid !== 1'b1 || inst !== 32'hA000_0054) begin
            errors++; $display("FAIL conflict_hit54: got valid=%0h inst=%h want 1/a0000054", valid, inst);
        end
        addr = 8'h14;
        #1;
        checks++; if (valid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL conflict_miss14: got valid=%0h stall=%0h want 0/1", valid, stall);
        end
        tick;
        for (int i = 0; i < 4; i++) tick;
        checks++; if (valid !== 1'b1 || inst !== 32'hA000_0014) begin
            errors++; $display("FAIL conflict_hit14: got valid=%0h inst=%h want 1/a0000014", valid, inst);
        end
        req = 1'b0;
        tick;
        checks++; if (hit_cnt !== 16'd5 || miss_cnt !== 16'd3) begin
            errors++; $display("FAIL conflict_counters: got hit=%0d miss=%0d want 5/3", hit_cnt, miss_cnt);
        end
    endtask

    // Ack every third cycle: 12 beat cycles, address holds between acks.
    task automatic test_ack_wait;
        logic [7:0] e;
        req = 1'b1; addr = 8'h20; mem_ack = 1'b0;
        #1;
        tick;
        for (int c = 0; c < 12; c++) begin
            mem_ack = ((c % 3) == 2);
            e = 8'h20 + 8'(c / 3);
            checks++; if (mem_req !== 1'b1 || mem_addr !== e) begin
                errors++; $display("FAIL wait_cycle%0d: got req=%0h addr=%h want 1/%h", c, mem_req, mem_addr, e);
            end
            tick;
        end
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 8'h20 + 8'(i);
            #1;
            checks++; if (valid !== 1'b1 || inst !== (32'hA000_0020 + 32'(i))) begin
                errors++; $display("FAIL wait_data%0d: got valid=%0h inst=%h want 1/%h", i, valid, inst, 32'hA000_0020 + 32'(i));
            end
        end
        req = 1'b0;
        tick;
        checks++; if (miss_cnt !== 16'd4) begin errors++; $display("FAIL wait_miss_cnt: got %0d want 4", miss_cnt); end
    endtask

    task automatic test_flush;
        req = 1'b1; addr = 8'h30; mem_ack = 1'b1;
        #1;
        tick;
        tick;
        flush = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h31) begin
            errors++; $display("FAIL flush_second_beat: got req=%0h addr=%h want 1/31", mem_req, mem_addr);
        end
        tick;
        flush = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || valid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL flush_abort: got req=%0h valid=%0h stall=%0h want 0/0/1", mem_req, valid, stall);
        end
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h30) begin
            errors++; $display("FAIL flush_refill_start: got req=%0h addr=%h want 1/30", mem_req, mem_addr);
        end
        for (int i = 0; i < 4; i++) tick;
        checks++; if (valid !== 1'b1 || inst !== 32'hA000_0030) begin
            errors++; $display("FAIL flush_refill_hit: got valid=%0h inst=%h want 1/a0000030", valid, inst);
        end
        flush = 1'b1;
        #1;
        checks++; if (valid !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_idle_prehit: got valid=%0h mem_req=%0h want 1/0", valid, mem_req);
        end
        tick;
        flush = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_idle_miss: got valid=%0h stall=%0h mem_req=%0h want 0/1/0", valid, stall, mem_req);
        end
        req = 1'b0;
        tick;
        checks++; if (hit_cnt !== 16'd6 || miss_cnt !== 16'd6) begin
            errors++; $display("FAIL flush_counters: got hit=%0d miss=%0d want 6/6", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_saturation;
        s_req = 1'b1; s_addr = 8'h05;
        #1;
        tick;
        for (int i = 0; i < 4; i++) tick;
        checks++; if (s_valid !== 1'b1 || s_inst !== 32'hA000_0005) begin
            errors++; $display("FAIL sat_first_hit: got valid=%0h inst=%h want 1/a0000005", s_valid, s_inst);
        end
        for (int i = 0; i < 14; i++) tick;
        checks++; if (s_hit_cnt !== 4'd14) begin errors++; $display("FAIL sat_hit14: got %0d want 14", s_hit_cnt); end
        for (int i = 0; i < 6; i++) tick;
        checks++; if (s_hit_cnt !== 4'd15 || s_miss_cnt !== 4'd1) begin
            errors++; $display("FAIL sat_hit20: got hit=%0d miss=%0d want 15/1", s_hit_cnt, s_miss_cnt);
        end
        s_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_line_reuse;
        test_conflict;
        test_ack_wait;
        test_flush;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
